// File: rtl/glb_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : glb_seg_pkg
// Description : Shared encodings for the global-mean segmentation controller:
//               phase select codes, controller state type, divider geometry,
//               divider job identifiers and the 8-bit saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package glb_seg_pkg;

    // Serial divider geometry: 32 quotient bits, done 33 cycles after launch.
    localparam int DIV_W   = 32;
    localparam int DIV_LAT = 33;

    // Phase select presented to the statistics datapath.
    localparam logic [1:0] PH_WAIT  = 2'd0;
    localparam logic [1:0] PH_MEAN  = 2'd1;
    localparam logic [1:0] PH_SPLIT = 2'd2;
    localparam logic [1:0] PH_SEG   = 2'd3;

    // Controller state, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_MEAN  = 2'd1,
        ST_SPLIT = 2'd2,
        ST_SEG   = 2'd3
    } seg_state_t;

    // Identifies which quotient the shared divider is working on.
    localparam logic [1:0] JOB_MEAN = 2'd0;
    localparam logic [1:0] JOB_M1   = 2'd1;
    localparam logic [1:0] JOB_M2   = 2'd2;

    // Clamp a 32-bit quotient into the 8-bit pixel range.
    function automatic logic [7:0] sat8(input logic [DIV_W-1:0] q);
        return (q > 32'd255) ? 8'hFF : q[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_div32.sv
`default_nettype none
// ============================================================================
// Module      : seq_div32
// Description : Serial restoring unsigned divider, one quotient bit per cycle.
//               Operands are captured on start; done pulses DIV_LAT cycles
//               after the start cycle. A zero divisor yields quotient 0 and
//               raises dz alongside the result. A new start restarts the unit
//               even while a job is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div32
    import glb_seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic             dz
);

    localparam logic [5:0] c_iter = 6'(DIV_LAT - 1);

    logic [DIV_W-1:0] r_quo;   // dividend shifts out, quotient shifts in
    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_dvs;
    logic [5:0]       r_cnt;
    logic             r_run;
    logic             r_done;
    logic             r_dz;

    logic [DIV_W:0]   w_rem_sh;
    logic             w_ge;
    logic [DIV_W-1:0] w_diff;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        w_rem_sh = {r_rem, r_quo[DIV_W-1]};
        w_ge     = (w_rem_sh >= {1'b0, r_dvs});
        w_diff   = w_rem_sh[DIV_W-1:0] - r_dvs;
    end

    // Operand capture on start, then DIV_W iterations ending in a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_quo <= dividend;
                r_rem <= '0;
                r_dvs <= divisor;
                r_dz  <= (divisor == '0);
                r_cnt <= c_iter;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_quo <= {r_quo[DIV_W-2:0], w_ge};
                r_rem <= w_ge ? w_diff : w_rem_sh[DIV_W-1:0];
                r_cnt <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign quotient = r_dz ? '0 : r_quo;
    assign dz       = r_dz;

endmodule
`default_nettype wire

// File: rtl/glb_seg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : glb_seg_ctrl
// Description : Frame-phase sequencer and divider scheduler for global-mean
//               threshold segmentation. Steps the datapath through MEAN and
//               SPLIT statistics frames, computes mean, m1 and m2 on a single
//               shared serial divider during blanking and publishes the
//               registered threshold (m1+m2)>>1.
// Revision    : 1.0 - initial release
// ============================================================================
module glb_seg_ctrl
    import glb_seg_pkg::*;
#(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int CONT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [31:0] sum_pixel,
    input  logic [31:0] under_sum,
    input  logic [23:0] under_cnt,
    input  logic [31:0] over_sum,
    input  logic [23:0] over_cnt,
    output logic [1:0]  phase,
    output logic [7:0]  mean,
    output logic [7:0]  m1,
    output logic [7:0]  m2,
    output logic [7:0]  threshold,
    output logic        thr_valid,
    output logic        thr_ready,
    output logic        busy,
    output logic        overrun,
    output logic        div_zero
);

    localparam logic [31:0] c_npix = 32'(H_DISP * V_DISP);

    logic             r_vsync_d;
    logic             w_nedge;
    seg_state_t       r_state;
    logic [1:0]       r_job;
    logic             r_thr_pend;

    logic             w_start;
    logic [DIV_W-1:0] w_dividend;
    logic [DIV_W-1:0] w_divisor;
    logic             w_done;
    logic [DIV_W-1:0] w_quo;
    logic             w_dz;

    // Delayed vsync for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
        end
    end

    assign w_nedge = ~vsync & r_vsync_d;

    // Divider launch and operand select: mean/m1 on a frame end, m2 chained
    // on m1 done. A frame end while busy launches nothing (it aborts).
    always_comb begin
        w_start    = 1'b0;
        w_dividend = sum_pixel;
        w_divisor  = c_npix;
        if (w_nedge && !busy) begin
            if (r_state == ST_MEAN) begin
                w_start = 1'b1;
            end else if (r_state == ST_SPLIT) begin
                w_start    = 1'b1;
                w_dividend = under_sum;
                w_divisor  = {8'd0, under_cnt};
            end
        end else if (!w_nedge && busy && w_done && (r_job == JOB_M1)) begin
            w_start    = 1'b1;
            w_dividend = over_sum;
            w_divisor  = {8'd0, over_cnt};
        end
    end

    seq_div32 u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .done     (w_done),
        .quotient (w_quo),
        .dz       (w_dz)
    );

    // Phase sequencer, job tracking and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_WAIT;
            r_job      <= JOB_MEAN;
            r_thr_pend <= 1'b0;
            phase      <= PH_WAIT;
            mean       <= '0;
            m1         <= '0;
            m2         <= '0;
            threshold  <= '0;
            thr_valid  <= 1'b0;
            thr_ready  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            thr_valid  <= 1'b0;
            r_thr_pend <= 1'b0;

            // Threshold follows one cycle after m2 has been written.
            if (r_thr_pend) begin
                threshold <= 8'(({1'b0, m1} + {1'b0, m2}) >> 1);
                thr_valid <= 1'b1;
                thr_ready <= 1'b1;
            end

            if (w_nedge) begin
                if (busy) begin
                    // Blanking too short: drop the job, keep old results.
                    overrun <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_MEAN;
                    phase   <= PH_MEAN;
                end else begin
                    case (r_state)
                        ST_WAIT: begin
                            r_state <= ST_MEAN;
                            phase   <= PH_MEAN;
                        end
                        ST_MEAN: begin
                            busy    <= 1'b1;
                            r_job   <= JOB_MEAN;
                            r_state <= ST_SPLIT;
                            phase   <= PH_SPLIT;
                        end
                        ST_SPLIT: begin
                            busy    <= 1'b1;
                            r_job   <= JOB_M1;
                            r_state <= ST_SEG;
                            phase   <= PH_SEG;
                        end
                        default: begin
                            if (CONT != 0) begin
                                r_state <= ST_MEAN;
                                phase   <= PH_MEAN;
                            end
                        end
                    endcase
                end
            end else if (busy && w_done) begin
                if (w_dz) begin
                    div_zero <= 1'b1;
                end
                case (r_job)
                    JOB_MEAN: begin
                        mean <= sat8(w_quo);
                        busy <= 1'b0;
                    end
                    JOB_M1: begin
                        m1    <= sat8(w_quo);
                        r_job <= JOB_M2;
                    end
                    default: begin
                        m2         <= sat8(w_quo);
                        busy       <= 1'b0;
                        r_thr_pend <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_glb_seg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_glb_seg_ctrl
// Description : Self-checking bench for glb_seg_ctrl on an 8x4 frame. Two
//               instances share the stimulus: one recomputing continuously,
//               one locking after the first threshold. Expected results come
//               from plain division with saturation and the frame-relative
//               cycle offsets of each result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glb_seg_ctrl;

    localparam int c_npix = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic [31:0] sum_pixel, under_sum, over_sum;
    logic [23:0] under_cnt, over_cnt;

    logic [1:0] phase, phase_0;
    logic [7:0] mean, m1, m2, threshold, mean_0, m1_0, m2_0, threshold_0;
    logic       thr_valid, thr_ready, busy, overrun, div_zero;
    logic       thr_valid_0, thr_ready_0, busy_0, overrun_0, div_zero_0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (what the continuous-mode DUT should show).
    int unsigned e_mean, e_m1, e_m2, e_thr;
    bit          e_ready, e_ovr, e_dz;

    always #5 clk = ~clk;

    glb_seg_ctrl #(.H_DISP(8), .V_DISP(4), .CONT(1)) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .sum_pixel(sum_pixel),
        .under_sum(under_sum), .under_cnt(under_cnt), .over_sum(over_sum),
        .over_cnt(over_cnt), .phase(phase), .mean(mean), .m1(m1), .m2(m2),
        .threshold(threshold), .thr_valid(thr_valid), .thr_ready(thr_ready),
        .busy(busy), .overrun(overrun), .div_zero(div_zero)
    );

    glb_seg_ctrl #(.H_DISP(8), .V_DISP(4), .CONT(0)) dut0 (
        .clk(clk), .rst(rst), .vsync(vsync), .sum_pixel(sum_pixel),
        .under_sum(under_sum), .under_cnt(under_cnt), .over_sum(over_sum),
        .over_cnt(over_cnt), .phase(phase_0), .mean(mean_0), .m1(m1_0),
        .m2(m2_0), .threshold(threshold_0), .thr_valid(thr_valid_0),
        .thr_ready(thr_ready_0), .busy(busy_0), .overrun(overrun_0),
        .div_zero(div_zero_0)
    );

    function automatic int unsigned q8(input longint unsigned a, input longint unsigned b);
        if (b == 0) return 0;
        return ((a / b) > 255) ? 255 : int'(a / b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame boundary; returns #1 after the edge on which nedge is sampled.
    task automatic do_vsync();
        @(negedge clk) vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        e_mean = 0; e_m1 = 0; e_m2 = 0; e_thr = 0;
        e_ready = 0; e_ovr = 0; e_dz = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".phase"}, 32'(phase), 0);
        chk({tag, ".mean"}, 32'(mean), 0);
        chk({tag, ".m1"}, 32'(m1), 0);
        chk({tag, ".m2"}, 32'(m2), 0);
        chk({tag, ".thr"}, 32'(threshold), 0);
        chk({tag, ".valid"}, 32'(thr_valid), 0);
        chk({tag, ".ready"}, 32'(thr_ready), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".ovr"}, 32'(overrun), 0);
        chk({tag, ".dz"}, 32'(div_zero), 0);
        chk({tag, ".phase0"}, 32'(phase_0), 0);
        chk({tag, ".busy0"}, 32'({mean_0, m1_0, m2_0, threshold_0}), 0);
        chk({tag, ".flags0"}, 32'({thr_valid_0, thr_ready_0, busy_0, overrun_0, div_zero_0}), 0);
    endtask

    task automatic enter_mean();
        do_vsync();
        chk("enter.phase", 32'(phase), 1);
        chk("enter.busy", 32'(busy), 0);
        repeat (3) step();
    endtask

    task automatic mean_job(input int unsigned s);
        int unsigned nm;
        @(negedge clk) sum_pixel = s;
        nm = q8(s, c_npix);
        do_vsync();
        chk("mean.phase", 32'(phase), 2);
        chk("mean.busy0", 32'(busy), 1);
        for (int k = 1; k <= 33; k++) begin
            step();
            chk("mean.busy", 32'(busy), (k <= 32) ? 1 : 0);
            chk("mean.val", 32'(mean), (k >= 33) ? nm : e_mean);
        end
        e_mean = nm;
        sum_pixel = $urandom;
        repeat (2) step();
    endtask

    task automatic split_job(input int unsigned us, input int unsigned uc,
                             input int unsigned os, input int unsigned oc);
        int unsigned n1, n2, nt;
        @(negedge clk);
        under_sum = us; under_cnt = 24'(uc); over_sum = os; over_cnt = 24'(oc);
        n1 = q8(us, uc);
        n2 = q8(os, oc);
        nt = (n1 + n2) / 2;
        if (uc == 0 || oc == 0) e_dz = 1;
        do_vsync();
        chk("split.phase", 32'(phase), 3);
        chk("split.busy0", 32'(busy), 1);
        for (int k = 1; k <= 70; k++) begin
            step();
            chk("split.valid", 32'(thr_valid), (k == 67) ? 1 : 0);
            chk("split.busy", 32'(busy), (k <= 65) ? 1 : 0);
            chk("split.thr", 32'(threshold), (k >= 67) ? nt : e_thr);
            if (k == 32 || k == 33) chk("split.m1", 32'(m1), (k >= 33) ? n1 : e_m1);
            if (k == 65 || k == 66) chk("split.m2", 32'(m2), (k >= 66) ? n2 : e_m2);
            if (k == 66) chk("split.ready_pre", 32'(thr_ready), 32'(e_ready));
            if (k == 67) chk("split.ready", 32'(thr_ready), 1);
        end
        chk("split.dz", 32'(div_zero), 32'(e_dz));
        chk("split.ovr", 32'(overrun), 32'(e_ovr));
        chk("split.phase_end", 32'(phase), 3);
        e_m1 = n1; e_m2 = n2; e_thr = nt; e_ready = 1;
    endtask

    // SPLIT launch followed by a frame end 20 cycles later while m1 runs.
    task automatic split_abort(input int unsigned us, input int unsigned uc,
                               input int unsigned os, input int unsigned oc);
        @(negedge clk);
        under_sum = us; under_cnt = 24'(uc); over_sum = os; over_cnt = 24'(oc);
        do_vsync();
        repeat (17) step();
        chk("abort.busy_pre", 32'(busy), 1);
        do_vsync();
        e_ovr = 1;
        chk("abort.phase", 32'(phase), 1);
        chk("abort.ovr", 32'(overrun), 1);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.thr", 32'(threshold), e_thr);
        for (int k = 1; k <= 70; k++) begin
            step();
            chk("abort.valid", 32'(thr_valid), 0);
            chk("abort.m1m2", 32'({m1, m2}), 32'({e_m1[7:0], e_m2[7:0]}));
            chk("abort.thr_hold", 32'(threshold), e_thr);
        end
        chk("abort.phase_end", 32'(phase), 1);
    endtask

    initial begin
        #1_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s, uc, oc, us, os;
        rst = 1'b1; vsync = 1'b0;
        sum_pixel = '0; under_sum = '0; under_cnt = '0; over_sum = '0; over_cnt = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (3) step();
        chk("wait.phase", 32'(phase), 0);

        // Pair 1: 16 px of 50 and 16 px of 150.
        enter_mean();
        mean_job(3200);
        chk("p1.mean", 32'(mean), 100);
        split_job(800, 16, 2400, 16);
        chk("p1.thr", 32'(threshold), 100);
        chk("p1.dz", 32'(div_zero), 0);
        chk("cont0.thr", 32'(threshold_0), 100);

        // Pair 2: 20/220, threshold moves 100 -> 120 at SPLIT+68.
        enter_mean();
        mean_job(3840);
        split_job(320, 16, 3520, 16);
        chk("p2.thr", 32'(threshold), 120);
        chk("p2.ready", 32'(thr_ready), 1);

        // Pair 3: constant 100, no pixels below the mean.
        enter_mean();
        mean_job(3200);
        split_job(0, 0, 3200, 32);
        chk("p3.m1", 32'(m1), 0);
        chk("p3.m2", 32'(m2), 100);
        chk("p3.thr", 32'(threshold), 50);
        chk("p3.dz", 32'(div_zero), 1);

        // Pair 4: overrun during the m1 job, then a full recovery pair.
        enter_mean();
        mean_job(3840);
        split_abort(320, 16, 3520, 16);
        mean_job(3840);
        split_job(320, 16, 3520, 16);
        chk("p4.ovr_sticky", 32'(overrun), 1);

        // Random pairs, including saturating quotients.
        for (int r = 0; r < 4; r++) begin
            s  = $urandom_range(0, c_npix * 320);
            uc = $urandom_range(0, 32);
            oc = 32 - uc;
            us = $urandom_range(0, uc * 300);
            os = $urandom_range(0, oc * 300 + 40);
            enter_mean();
            mean_job(s);
            split_job(us, uc, os, oc);
        end

        // Reset 10 cycles into a mean job.
        enter_mean();
        @(negedge clk) sum_pixel = 3200;
        do_vsync();
        repeat (9) step();
        chk("rst.busy_pre", 32'(busy), 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk_zero("midrst");
        @(negedge clk) rst = 1'b0;
        repeat (40) step();
        chk("rst.quiet", 32'({phase, mean, busy, thr_valid}), 0);

        // Fresh sequence on both instances.
        enter_mean();
        mean_job(2560);
        split_job(960, 24, 1600, 8);
        chk("fresh.thr", 32'(threshold), 120);
        chk("cont0.fresh_thr", 32'(threshold_0), 120);
        chk("cont0.ready", 32'(thr_ready_0), 1);

        // Locked instance must ignore three further frames.
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            sum_pixel = $urandom; under_sum = $urandom; under_cnt = 24'($urandom_range(1, 32));
            over_sum = $urandom; over_cnt = 24'($urandom_range(1, 32));
            do_vsync();
            for (int k = 0; k < 80; k++) begin
                step();
                chk("cont0.phase", 32'(phase_0), 3);
                chk("cont0.valid", 32'(thr_valid_0), 0);
                chk("cont0.thr_hold", 32'(threshold_0), 120);
            end
        end
        chk("cont0.busy", 32'(busy_0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/glb_seg_ctrl.md
Name: glb_seg_ctrl

Overview:
- Frame-phase sequencer and divider scheduler for the global-mean threshold segmentation pipeline.
- Drives the phase select that the statistics datapath uses: MEAN accumulate, SPLIT accumulate, SEGMENT.
- A single shared serial divider computes all three quotients (mean, m1, m2) in vertical blanking, instead of three combinational dividers.
- Produces the registered threshold consumed by the segmentation compare stage.

Parameters:
- H_DISP, 640, active pixels per line.
- V_DISP, 480, active lines per frame.
- CONT, 1, 1 = recompute the threshold continuously (MEAN→SPLIT→SEG→MEAN…); 0 = lock in SEG after first threshold.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- vsync  in  1  frame sync, same timing as Y stream.
- sum_pixel  in  32  datapath total sum, stable from vsync falling edge until the next de.
- under_sum  in  32  sum of pixels < mean.
- under_cnt  in  24  count of pixels < mean.
- over_sum  in  32  sum of pixels ≥ mean.
- over_cnt  in  24  count of pixels ≥ mean.
- phase  out  2  0=WAIT, 1=MEAN, 2=SPLIT, 3=SEG; tells the datapath what to accumulate.
- mean  out  8  global mean.
- m1  out  8  mean of the lower class.
- m2  out  8  mean of the upper class.
- threshold  out  8  (m1+m2)>>1.
- thr_valid  out  1  one-cycle pulse when threshold updates.
- thr_ready  out  1  level; high once the first threshold is computed.
- busy  out  1  divider job in flight.
- overrun  out  1  sticky; a frame ended while busy.
- div_zero  out  1  sticky; a divisor was 0.

Behaviour:
- Reset: every output is 0, FSM is in WAIT, divider is idle.
- vsync is registered once. nedge = ~vsync & vsync_d, asserted one cycle after the falling edge.
- Phase sequence:
  - WAIT: on nedge → MEAN. Discards the partial frame.
  - MEAN: on nedge → launch the mean job, then → SPLIT.
  - SPLIT: on nedge → launch the m1 job. m2 is launched automatically on m1 done. Then → SEG.
  - SEG: on nedge → MEAN if CONT=1; otherwise stay in SEG.
- phase changes in the cycle after nedge. The datapath samples phase at the next de.
- Divider jobs:
  - mean = sum_pixel / (H_DISP*V_DISP).
  - m1 = under_sum / under_cnt (zero-extended to 32 bits).
  - m2 = over_sum / over_cnt.
  - Dividend/divisor are captured on the launch cycle.
  - Restoring, 1 bit per cycle, 32 iterations. done pulses exactly 33 cycles after launch.
  - Quotient > 255 saturates to 255.
  - Divisor 0: quotient = 0 and div_zero is set.
- Register updates:
  - mean/m1/m2 update in the cycle after the matching done.
  - threshold = 9-bit (m1+m2)>>1, registered in the cycle after m2 updates.
  - thr_valid pulses in that same cycle; thr_ready is set then.
  - Timing from SPLIT nedge: m2 done at +66; threshold/thr_valid at +68.
- busy is high from launch through the m2 done (mean job: launch through its done).
- nedge while busy:
  - Set overrun and abort the in-flight job.
  - Keep the old mean/m1/m2/threshold.
  - FSM → MEAN, restarting the sequence. No thr_valid pulse.
- With CONT=1, threshold holds its old value while the new pair of stat frames is gathered. thr_ready stays high.
- rst mid-job clears everything in the same edge. No pending job survives.
- sticky flags clear only on rst.

Decomposition:
- Package glb_seg_pkg holds:
  - phase encodings PH_WAIT/PH_MEAN/PH_SPLIT/PH_SEG;
  - FSM state enum;
  - DIV_W=32 and DIV_LAT=33;
  - the job-id encodings JOB_MEAN/JOB_M1/JOB_M2.
- One sub-module: seq_div32, the serial restoring divider.
  - Inputs: start, dividend[31:0], divisor[31:0].
  - Outputs: done, quotient[31:0], dz.
  - It is also reusable by other stats blocks.

Test Plan:
- H_DISP=8, V_DISP=4 (32 px). Frames are 16 px of 50 and 16 px of 150: sum=3200, under 800/16, over 2400/16. Required: mean=100 at MEAN-nedge+34; m1=50, m2=150; threshold=100; thr_valid at SPLIT-nedge+68; phase sequence 0→1→2→3.
- Constant frame of 100: under_cnt=0. Required: m1=0, div_zero=1, m2=100, threshold=50.
- nedge injected 20 cycles after the SPLIT launch. Required: overrun=1; threshold unchanged; phase=1 next cycle; no thr_valid pulse.
- CONT=0 after the first threshold, 3 further frames. Required: phase stays 3; no further thr_valid; threshold stable.
- CONT=1 with the second frame pair at 20/220. Required: threshold becomes 120 exactly at the second-pair SPLIT-nedge+68; it holds 100 before that.
- rst asserted 10 cycles into the mean job. Required: all outputs 0 next cycle; busy=0; phase=0; a fresh sequence works afterwards.
